io_port_controller: RTL and testbench

Buffered I/O controller for the 16-bit data path, sitting directly beside the data memory wrapper at the memory-mapped I/O address 0x0000. CPU stores to address 0 are queued in a transmit FIFO and drained to an external consumer over a valid/ready handshake. External producers push words into a receive FIFO whose head feeds the wrapper's input-port value, which is popped by CPU loads from address 0. Both directions decouple the single-cycle CPU memory stage from slow external devices.

---
 rtl/io_port_controller_pkg.sv | 13 +
 rtl/io_fifo.sv | 56 +++++
 rtl/io_port_controller.sv | 87 ++++++++
 tb/tb_io_port_controller.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_controller_pkg.sv
// Shared constants for the memory-mapped I/O port controller: port address,
// default FIFO depth and data word width.
package io_port_controller_pkg;

  localparam logic [15:0] IO_ADDR       = 16'h0000;
  localparam int          DEFAULT_DEPTH = 4;
  localparam int          DATA_WIDTH    = 16;

  function automatic logic is_io_addr(input logic [15:0] addr);
    return addr == IO_ADDR;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO: head is read straight from storage
// while non-empty. Push on full and pop on empty are ignored.
import io_port_controller_pkg::*;

module io_fifo #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_controller.sv
// Buffered I/O port at the memory-mapped I/O address: CPU stores feed a tx FIFO,
// CPU loads drain an rx FIFO. Optional feature macro: IO_STALL_EN.
import io_port_controller_pkg::*;

module io_port_controller #(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int WIDTH = DATA_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      cpu_addr,
  input  logic [15:0]      cpu_data,
  input  logic             cpu_we,
  input  logic             cpu_re,
  output logic [15:0]      cpu_rdata,
  output logic             stall,
  output logic [WIDTH-1:0] tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  input  logic [WIDTH-1:0] rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic             ovf,
  output logic             unf
);

  logic             io_hit;
  logic             tx_full, tx_empty, tx_push, tx_pop;
  logic             rx_full, rx_empty, rx_push, rx_pop;
  logic [WIDTH-1:0] rx_head;

  assign io_hit  = is_io_addr(cpu_addr);
  assign tx_push = cpu_we & io_hit & ~tx_full;
  assign rx_pop  = cpu_re & io_hit & ~rx_empty;

  // External ports: a word moves on a rising edge where valid & ready are both
  // high. tx_valid and rx_ready come only from registered FIFO counts, so
  // neither depends combinationally on the partner's ready/valid.
  assign tx_valid = ~tx_empty;
  assign rx_ready = ~rx_full;
  assign tx_pop   = tx_valid & tx_ready;
  assign rx_push  = rx_valid & rx_ready;

  assign cpu_rdata = rx_empty ? 16'h0000 : rx_head;

  io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_tx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (tx_push),
    .pop   (tx_pop),
    .din   (cpu_data),
    .head  (tx_data),
    .full  (tx_full),
    .empty (tx_empty)
  );

  io_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_rx_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rx_push),
    .pop   (rx_pop),
    .din   (rx_data),
    .head  (rx_head),
    .full  (rx_full),
    .empty (rx_empty)
  );

`ifdef IO_STALL_EN
  // The CPU retries a blocked access, so nothing is ever lost.
  assign stall = io_hit & ((cpu_we & tx_full) | (cpu_re & rx_empty));
  assign ovf   = 1'b0;
  assign unf   = 1'b0;
`else
  assign stall = 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (cpu_we & io_hit & tx_full)  ovf <= 1'b1;
      if (cpu_re & io_hit & rx_empty) unf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_io_port_controller.sv
// Directed testbench for io_port_controller: reset, tx ordering and full-FIFO
// handling, rx underflow, wrap-around, address decode, reset mid-transfer.
module tb_io_port_controller;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk;
  logic             rst_n;
  logic [15:0]      cpu_addr;
  logic [15:0]      cpu_data;
  logic             cpu_we;
  logic             cpu_re;
  logic [15:0]      cpu_rdata;
  logic             stall;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             ovf;
  logic             unf;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] tx_q[$];
  logic [WIDTH-1:0] rx_q[$];

  io_port_controller #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_addr  (cpu_addr),
    .cpu_data  (cpu_data),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .ovf       (ovf),
    .unf       (unf)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One-cycle CPU store; accept says whether the tx FIFO should take the word.
  task automatic store(input logic [15:0] addr, input logic [15:0] data, input bit accept);
    cpu_addr = addr;
    cpu_data = data;
    cpu_we   = 1'b1;
    #1;
`ifdef IO_STALL_EN
    check("store_stall", stall, {31'd0, (addr == 16'h0000) && !accept});
`else
    check("store_stall", stall, 0);
`endif
    tick();
    cpu_we = 1'b0;
    if (accept) tx_q.push_back(data);
  endtask

  // Drain n words from the tx port against the expected queue.
  task automatic drain(input int n);
    tx_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", tx_valid, 1);
      check("drain_data", tx_data, tx_q.pop_front());
      tick();
    end
    tx_ready = 1'b0;
    check("drain_empty", tx_valid, 0);
  endtask

  task automatic rx_send(input logic [15:0] data);
    rx_data  = data;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_q.push_back(data);
  endtask

  initial begin
    rst_n    = 1'b1;
    cpu_addr = 16'h0000;
    cpu_data = 16'h0000;
    cpu_we   = 1'b0;
    cpu_re   = 1'b0;
    tx_ready = 1'b0;
    rx_data  = '0;
    rx_valid = 1'b0;

    // Reset asserted mid-cycle takes effect immediately
    tick();
    tick();
    #3 rst_n = 1'b0;
    #1;
    check("rst_tx_valid", tx_valid, 0);
    check("rst_rx_ready", rx_ready, 1);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_stall", stall, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_tx_valid", tx_valid, 0);
    check("post_rst_rx_ready", rx_ready, 1);
    check("post_rst_cpu_rdata", cpu_rdata, 0);

    // Two stores drain in order
    store(16'h0000, 16'h1234, 1);
    check("st1_tx_valid", tx_valid, 1);
    check("st1_tx_data", tx_data, 16'h1234);
    store(16'h0000, 16'h5678, 1);
    check("st2_tx_data", tx_data, 16'h1234);
    drain(2);

    // Fill tx, then store into a full FIFO (rejected)
    store(16'h0000, 16'hA000, 1);
    store(16'h0000, 16'hA001, 1);
    store(16'h0000, 16'hA002, 1);
    store(16'h0000, 16'hA003, 1);
    check("full_tx_valid", tx_valid, 1);
    store(16'h0000, 16'hA004, 0);
`ifdef IO_STALL_EN
    check("full_ovf", ovf, 0);
`else
    check("full_ovf", ovf, 1);
`endif

    // Full with a same-cycle pop: store still rejected, A000 leaves
    tx_ready = 1'b1;
    #1;
    check("full_pop_head", tx_data, 16'hA000);
    void'(tx_q.pop_front());
    store(16'h0000, 16'hA005, 0);
    drain(3);

    // Non-zero address is ignored
    store(16'h0002, 16'hDEAD, 0);
    check("decode_tx_valid", tx_valid, 0);
`ifdef IO_STALL_EN
    check("decode_ovf", ovf, 0);
`else
    check("decode_ovf_sticky", ovf, 1);
`endif

    // Load from empty rx
    cpu_addr = 16'h0000;
    cpu_re   = 1'b1;
    #1;
    check("unf_rdata", cpu_rdata, 0);
`ifdef IO_STALL_EN
    check("unf_stall", stall, 1);
`else
    check("unf_stall", stall, 0);
`endif
    tick();
    cpu_re = 1'b0;
`ifdef IO_STALL_EN
    check("unf_flag", unf, 0);
`else
    check("unf_flag", unf, 1);
`endif

    // Producer word becomes visible the next cycle
    check("rx_ready_empty", rx_ready, 1);
    rx_send(16'hBEEF);
    check("rx_beef", cpu_rdata, 16'hBEEF);
    cpu_re = 1'b1;
    tick();
    cpu_re = 1'b0;
    void'(rx_q.pop_front());
    check("rx_after_pop", cpu_rdata, 0);

    // Wrap-around with simultaneous push and pop
    rx_send(16'h1000);
    for (int i = 1; i <= 10; i++) begin
      rx_data  = 16'h1000 + 16'(i);
      rx_valid = 1'b1;
      cpu_re   = 1'b1;
      #1;
      check("wrap_head", cpu_rdata, rx_q[0]);
      check("wrap_rx_ready", rx_ready, 1);
      tick();
      void'(rx_q.pop_front());
      rx_q.push_back(16'h1000 + 16'(i));
    end
    rx_valid = 1'b0;
    cpu_re   = 1'b0;
    #1;
    check("wrap_last", cpu_rdata, 16'h100A);

    // Fill rx to DEPTH: rx_ready drops and further words are refused
    rx_send(16'h2001);
    rx_send(16'h2002);
    rx_send(16'h2003);
    check("rx_full_ready", rx_ready, 0);
    rx_data  = 16'hFFFF;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      check("rx_drain", cpu_rdata, rx_q.pop_front());
      cpu_re = 1'b1;
      tick();
      cpu_re = 1'b0;
    end
    check("rx_drain_empty", cpu_rdata, 0);
    check("rx_drain_ready", rx_ready, 1);

    // Reset mid-transfer discards queued words and clears sticky flags
    store(16'h0000, 16'hCAFE, 1);
    rx_send(16'h7777);
    check("pre_rst_tx_valid", tx_valid, 1);
    check("pre_rst_rdata", cpu_rdata, 16'h7777);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_tx_valid", tx_valid, 0);
    check("mid_rst_rdata", cpu_rdata, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_unf", unf, 0);
    tx_q.delete();
    rx_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check("end_tx_valid", tx_valid, 0);
    check("end_rx_ready", rx_ready, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
